// File: rtl/d_mem_responder.sv
// Data-memory slave for the core's D_MEM_* port: byte-enabled writes, full-word
// reads returned through a fixed-latency valid pipeline, saturating access counters.
module d_mem_responder #(
    parameter int DEPTH   = 4096,
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              D_MEM_CSN,
    input  logic              D_MEM_WEN,
    input  logic [ADDR_W-1:0] D_MEM_ADDR,
    input  logic [3:0]        D_MEM_BE,
    input  logic [31:0]       D_MEM_DOUT,
    output logic [31:0]       D_MEM_DI,
    output logic              D_MEM_RVALID,
    output logic [31:0]       RD_CNT,
    output logic [31:0]       WR_CNT
);

    localparam int IDX_W = $clog2(DEPTH);

    logic             w_rd_acc;
    logic             w_wr_acc;
    logic [IDX_W-1:0] w_idx;

    // Dropping the upper address bits is what makes out-of-range addresses wrap.
    assign w_idx    = D_MEM_ADDR[IDX_W-1:0];
    assign w_rd_acc = !RST && !D_MEM_CSN &&  D_MEM_WEN;
    assign w_wr_acc = !RST && !D_MEM_CSN && !D_MEM_WEN;

    // NOTE: the array has no reset branch; it starts at zero and keeps its
    // contents across RST, which also lets it map onto block RAM.
    logic [31:0] r_mem [DEPTH] = '{default: '0};

    always_ff @(posedge CLK) begin
        if (w_wr_acc) begin
            for (int i = 0; i < 4; i++) begin
                if (D_MEM_BE[i]) begin
                    r_mem[w_idx][8*i +: 8] <= D_MEM_DOUT[8*i +: 8];
                end
            end
        end
    end

    logic [LATENCY-1:0] r_vld;
    logic [31:0]        r_dat [LATENCY];

    // Data in a stage only advances alongside its valid bit, so the last stage
    // (which drives D_MEM_DI) holds its value between results.
    // NOTE: all sequential state uses non-blocking assignments so every stage
    // samples its predecessor's value from before the edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vld            <= '0;
            r_dat[LATENCY-1] <= '0;
        end else begin
            r_vld[0] <= w_rd_acc;
            if (w_rd_acc) begin
                r_dat[0] <= r_mem[w_idx];
            end
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_dat[i] <= r_dat[i-1];
                end
            end
        end
    end

    assign D_MEM_DI     = r_dat[LATENCY-1];
    assign D_MEM_RVALID = r_vld[LATENCY-1];

    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_rd_acc && (r_rd_cnt != '1)) begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
            if (w_wr_acc && (r_wr_cnt != '1)) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
        end
    end

    assign RD_CNT = r_rd_cnt;
    assign WR_CNT = r_wr_cnt;

endmodule

// File: tb/tb_d_mem_responder.sv
// Directed bench for d_mem_responder: one instance at LATENCY=2 and one at
// LATENCY=3, both DEPTH=1024, sharing request inputs but with separate resets.
module tb_d_mem_responder;

    logic        clk;
    logic        rst_a;
    logic        rst_b;
    logic        csn;
    logic        wen;
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] dout;

    logic [31:0] di_a, rc_a, wc_a;
    logic [31:0] di_b, rc_b, wc_b;
    logic        rv_a, rv_b;

    int n_tests = 0;
    int n_fail  = 0;

    d_mem_responder #(.DEPTH(1024), .ADDR_W(12), .LATENCY(2)) dut_a (
        .CLK(clk), .RST(rst_a),
        .D_MEM_CSN(csn), .D_MEM_WEN(wen), .D_MEM_ADDR(addr),
        .D_MEM_BE(be), .D_MEM_DOUT(dout),
        .D_MEM_DI(di_a), .D_MEM_RVALID(rv_a),
        .RD_CNT(rc_a), .WR_CNT(wc_a)
    );

    d_mem_responder #(.DEPTH(1024), .ADDR_W(12), .LATENCY(3)) dut_b (
        .CLK(clk), .RST(rst_b),
        .D_MEM_CSN(csn), .D_MEM_WEN(wen), .D_MEM_ADDR(addr),
        .D_MEM_BE(be), .D_MEM_DOUT(dout),
        .D_MEM_DI(di_b), .D_MEM_RVALID(rv_b),
        .RD_CNT(rc_b), .WR_CNT(wc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
        csn = 1'b0; wen = 1'b0; addr = a; dout = d; be = b;
    endtask

    task automatic rd(input logic [11:0] a);
        csn = 1'b0; wen = 1'b1; addr = a; dout = '0; be = 4'h0;
    endtask

    task automatic idle();
        csn = 1'b1; wen = 1'b1; addr = '0; dout = '0; be = 4'h0;
    endtask

    initial begin
        // Reset held for three edges while a write is presented
        rst_a = 1'b1;
        rst_b = 1'b1;
        wr(12'h010, 32'hFFFF_FFFF, 4'hF);
        repeat (3) step();
        check("rst_di",   di_a, 32'h0);
        check("rst_rv",   32'(rv_a), 32'd0);
        check("rst_rdcnt", rc_a, 32'd0);
        check("rst_wrcnt", wc_a, 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        rd(12'h010);
        step();
        idle();
        step();
        check("rst_rd_rv", 32'(rv_a), 32'd1);
        check("rst_rd_di", di_a, 32'h0);
        check("rst_rd_wrcnt", wc_a, 32'd0);

        // Full write then read-after-write, latency on both instances
        wr(12'h004, 32'hDEAD_BEEF, 4'hF);
        step();
        rd(12'h004);
        step();
        check("raw_rv_early", 32'(rv_a), 32'd0);
        idle();
        step();
        check("raw_rv_a",   32'(rv_a), 32'd1);
        check("raw_di_a",   di_a, 32'hDEAD_BEEF);
        check("raw_rv_b_early", 32'(rv_b), 32'd0);
        step();
        check("raw_rv_a_drop", 32'(rv_a), 32'd0);
        check("raw_di_a_hold", di_a, 32'hDEAD_BEEF);
        check("raw_rv_b",   32'(rv_b), 32'd1);
        check("raw_di_b",   di_b, 32'hDEAD_BEEF);
        check("raw_rdcnt",  rc_a, 32'd2);
        check("raw_wrcnt",  wc_a, 32'd1);

        // Byte-enable merge and a BE=0000 write
        wr(12'h020, 32'h1122_3344, 4'hF);
        step();
        wr(12'h020, 32'hAABB_CCDD, 4'b0101);
        step();
        rd(12'h020);
        step();
        idle();
        step();
        check("be_rv", 32'(rv_a), 32'd1);
        check("be_di", di_a, 32'h11BB_33DD);
        wr(12'h020, 32'hFFFF_FFFF, 4'h0);
        step();
        rd(12'h020);
        step();
        idle();
        step();
        check("be0_di",    di_a, 32'h11BB_33DD);
        check("be0_wrcnt", wc_a, 32'd4);

        // Preload then four back-to-back reads
        for (int i = 1; i <= 4; i++) begin
            wr(12'(i), 32'(i), 4'hF);
            step();
        end
        for (int i = 1; i <= 4; i++) begin
            rd(12'(i));
            step();
            if (i == 1) begin
                check("pipe_rv_first", 32'(rv_a), 32'd0);
            end else begin
                check($sformatf("pipe_rv_%0d", i - 1), 32'(rv_a), 32'd1);
                check($sformatf("pipe_di_%0d", i - 1), di_a, 32'(i - 1));
            end
        end
        idle();
        step();
        check("pipe_rv_4", 32'(rv_a), 32'd1);
        check("pipe_di_4", di_a, 32'd4);
        step();
        check("pipe_rv_end", 32'(rv_a), 32'd0);
        check("pipe_di_hold", di_a, 32'd4);

        // Write to 0x002 while its read is in flight
        rd(12'h002);
        step();
        wr(12'h002, 32'h0000_0099, 4'hF);
        step();
        check("inflight_rv", 32'(rv_a), 32'd1);
        check("inflight_di", di_a, 32'd2);
        idle();
        step();
        rd(12'h002);
        step();
        idle();
        step();
        check("after_wr_di", di_a, 32'h0000_0099);
        check("ord_rdcnt", rc_a, 32'd10);
        check("ord_wrcnt", wc_a, 32'd9);

        // Address wrap at DEPTH=1024
        wr(12'h405, 32'h5A5A_5A5A, 4'hF);
        step();
        rd(12'h005);
        step();
        idle();
        step();
        check("wrap_di_a", di_a, 32'h5A5A_5A5A);
        step();
        check("wrap_rv_b", 32'(rv_b), 32'd1);
        check("wrap_di_b", di_b, 32'h5A5A_5A5A);

        // Reset mid-flight on the LATENCY=3 instance
        wr(12'h100, 32'hCAFE_F00D, 4'hF);
        step();
        rd(12'h100);
        step();
        idle();
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        check("mid_rst_rv",    32'(rv_b), 32'd0);
        check("mid_rst_di",    di_b, 32'h0);
        check("mid_rst_rdcnt", rc_b, 32'd0);
        check("mid_rst_wrcnt", wc_b, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("mid_rst_norv_%0d", i), 32'(rv_b), 32'd0);
        end
        check("mid_rst_di_hold", di_b, 32'h0);
        rd(12'h100);
        step();
        idle();
        step();
        check("retain_rv_early", 32'(rv_b), 32'd0);
        step();
        check("retain_rv", 32'(rv_b), 32'd1);
        check("retain_di", di_b, 32'hCAFE_F00D);
        check("retain_rdcnt", rc_b, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
